// File: rtl/dma_irq_guard_pkg.sv
// Shared definitions for dma_irq_guard.
//   state_t     : guard FSM states (RUN, KILL, ARMED)
//   CAUSE_*     : bit positions inside viol_cause
package dma_irq_guard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    KILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  localparam int CAUSE_PC_DMA = 0;
  localparam int CAUSE_ADDR   = 1;
  localparam int CAUSE_IRQ    = 2;
  localparam int CAUSE_W      = 3;

  localparam int HOLD_W       = 8;

endpackage

// File: rtl/region_cmp.sv
// Inclusive [lo, hi] unsigned range comparator.
//   addr : address under test (ADDR_W)
//   lo   : lower bound, ADDR_W+1 bits so callers can pass unwrapped sums
//   hi   : upper bound, ADDR_W+1 bits
//   hit  : lo <= addr <= hi
module region_cmp #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W:0]   lo,
  input  logic [ADDR_W:0]   hi,
  output logic              hit
);

  logic [ADDR_W:0] addr_x;

  assign addr_x = {1'b0, addr};
  assign hit    = (addr_x >= lo) && (addr_x <= hi);

endmodule

// File: rtl/dma_irq_guard.sv
// Secure-region isolation guard. Watches pc, N_DMA DMA channels and irq and
// holds the core in reset (reset=1) after any isolation break, until a
// minimum hold time has elapsed and the core fetches from RESET_HANDLER.
//   clk, reset_n : clock, async active-low reset
//   pc           : program counter
//   dma_addr     : packed per-channel addresses, channel i at [i*ADDR_W +: ADDR_W]
//   dma_en       : per-channel access strobe
//   irq          : interrupt being taken
//   clr_cnt      : synchronous clear of viol_cnt (wins over increment)
//   reset, run   : kill request and its inverse (registered)
//   viol_cause   : {irq, addr, pc_dma} latched on RUN->KILL
//   viol_chan    : lowest contributing DMA channel latched on RUN->KILL
//   viol_cnt     : saturating count of RUN->KILL transitions
module dma_irq_guard
  import dma_irq_guard_pkg::*;
#(
  parameter int          ADDR_W         = 16,
  parameter int unsigned REGION_BASE    = 'hA000,
  parameter int unsigned REGION_SIZE    = 'h1000,
  parameter int          N_DMA          = 2,
  parameter int unsigned RESET_HANDLER  = 'h0000,
  parameter bit          CHECK_IRQ      = 1'b1,
  parameter bit          GUARD_DMA_ADDR = 1'b1,
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int          CNT_W          = 8,
  localparam int         CH_W           = (N_DMA > 1) ? $clog2(N_DMA) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_W-1:0]         pc,
  input  logic [N_DMA*ADDR_W-1:0]   dma_addr,
  input  logic [N_DMA-1:0]          dma_en,
  input  logic                      irq,
  input  logic                      clr_cnt,
  output logic                      reset,
  output logic                      run,
  output logic [CAUSE_W-1:0]        viol_cause,
  output logic [CH_W-1:0]           viol_chan,
  output logic [CNT_W-1:0]          viol_cnt
);

  // Bounds at ADDR_W+1 bits so base+size never wraps.
  localparam logic [ADDR_W:0] BASE_X = (ADDR_W+1)'(REGION_BASE);
  localparam logic [ADDR_W:0] SIZE_X = (ADDR_W+1)'(REGION_SIZE);
  localparam logic [ADDR_W:0] LAST_X = BASE_X + SIZE_X - (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] TOP_X  = BASE_X + SIZE_X - (ADDR_W+1)'(1);

  localparam logic [ADDR_W-1:0] HANDLER  = ADDR_W'(RESET_HANDLER);
  localparam logic [HOLD_W-1:0] HOLD     = HOLD_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  // ---------------------------------------------------------------- predicates
  logic             pc_in;
  logic [N_DMA-1:0] addr_in;

  // pc is word-aligned, so its last legal value is two below the end.
  region_cmp #(.ADDR_W(ADDR_W)) u_pc_cmp (
    .addr (pc),
    .lo   (BASE_X),
    .hi   (LAST_X),
    .hit  (pc_in)
  );

  for (genvar i = 0; i < N_DMA; i++) begin : g_dma_cmp
    region_cmp #(.ADDR_W(ADDR_W)) u_dma_cmp (
      .addr (dma_addr[i*ADDR_W +: ADDR_W]),
      .lo   (BASE_X),
      .hi   (TOP_X),
      .hit  (addr_in[i])
    );
  end

  logic             c_pc_dma, c_addr, c_irq, viol;
  logic [N_DMA-1:0] addr_hit, chan_mask;
  logic [CH_W-1:0]  chan_sel;

  assign addr_hit = dma_en & addr_in;
  assign c_pc_dma = pc_in & (|dma_en);
  assign c_addr   = GUARD_DMA_ADDR & (|addr_hit);
  assign c_irq    = CHECK_IRQ & pc_in & irq;
  assign viol     = c_pc_dma | c_addr | c_irq;

  // A channel contributes if it fired while pc is inside the region, or if
  // it targeted the region with the address guard enabled.
  assign chan_mask = (pc_in ? dma_en : '0) | (GUARD_DMA_ADDR ? addr_hit : '0);

  // Lowest set bit wins: scan high to low so the last hit is the lowest.
  always_comb begin
    chan_sel = '0;
    for (int i = N_DMA-1; i >= 0; i--) begin
      if (chan_mask[i]) chan_sel = CH_W'(i);
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t             state, state_n;
  logic [HOLD_W-1:0]  hold, hold_n;
  logic [CAUSE_W-1:0] cause_n;
  logic [CH_W-1:0]    chan_n;
  logic [CNT_W-1:0]   cnt_n;

  always_comb begin
    state_n = state;
    hold_n  = hold;
    cause_n = viol_cause;
    chan_n  = viol_chan;
    cnt_n   = viol_cnt;
    case (state)
      RUN: begin
        if (viol) begin
          state_n = KILL;
          hold_n  = '0;
          cause_n[CAUSE_PC_DMA] = c_pc_dma;
          cause_n[CAUSE_ADDR]   = c_addr;
          cause_n[CAUSE_IRQ]    = c_irq;
          chan_n  = chan_sel;
          if (viol_cnt != CNT_MAX) cnt_n = viol_cnt + CNT_W'(1);
        end
      end
      KILL: begin
        // Any violation restarts the hold window; hold saturates at HOLD.
        if (viol)              hold_n  = '0;
        else if (hold == HOLD) state_n = ARMED;
        else                   hold_n  = hold + HOLD_W'(1);
      end
      ARMED: begin
        if (viol) begin
          state_n = KILL;
          hold_n  = '0;
        end else if (pc == HANDLER) begin
          state_n = RUN;
        end
      end
      default: begin
        state_n = KILL;
        hold_n  = '0;
      end
    endcase
    if (clr_cnt) cnt_n = '0;
  end

  // reset/run are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= KILL;
      hold       <= '0;
      viol_cause <= '0;
      viol_chan  <= '0;
      viol_cnt   <= '0;
      reset      <= 1'b1;
      run        <= 1'b0;
    end else begin
      state      <= state_n;
      hold       <= hold_n;
      viol_cause <= cause_n;
      viol_chan  <= chan_n;
      viol_cnt   <= cnt_n;
      reset      <= (state_n != RUN);
      run        <= (state_n == RUN);
    end
  end

endmodule

// File: doc/dma_irq_guard.md
# dma_irq_guard

Parametrised guard for the protected secure-memory region: watches the MSP430 program counter, `N_DMA` DMA request channels and the interrupt line, and holds the core in reset after any access that breaks the region's isolation. It supersedes the single-channel DMA/IRQ detector in the hardware-monitor stack. It sits beside the other monitors, and its `reset` output is OR-ed into the system reset. It adds the following:
- a DMA address check that applies even when code runs outside the region;
- a minimum kill-hold time;
- a cause/channel capture;
- a saturating violation counter.

## Interface
Parameters:
- `ADDR_W`, 16: address width of `pc` and each DMA address.
- `REGION_BASE`, 16'hA000: first byte of the protected region.
- `REGION_SIZE`, 16'h1000: region size in bytes. It must be even and ≥2, and `REGION_BASE+REGION_SIZE` must not exceed 2^`ADDR_W`.
- `N_DMA`, 2: number of DMA channels, 1..8.
- `RESET_HANDLER`, 16'h0000: PC value that releases the kill.
- `CHECK_IRQ`, 1: 1 means an `irq` while PC is in the region is a violation.
- `GUARD_DMA_ADDR`, 1: 1 means a DMA targeting the region is a violation regardless of PC.
- `HOLD_CYCLES`, 4: minimum number of cycles spent in KILL before the block can arm, 0..255.
- `CNT_W`, 8: width of the violation counter.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `pc` in `ADDR_W`: current program counter.
- `dma_addr` in `N_DMA*ADDR_W`: channel i occupies bits [i*ADDR_W +: ADDR_W].
- `dma_en` in `N_DMA`: per-channel access strobe.
- `irq` in 1: interrupt being taken.
- `clr_cnt` in 1: synchronous clear of `viol_cnt`.
- `reset` out 1: kill/reset request, active-high.
- `run` out 1: high when the block is in RUN.
- `viol_cause` out 3: cause bits latched at the last RUN→KILL transition.
- `viol_chan` out `$clog2(N_DMA)` (minimum 1): lowest-indexed offending channel.
- `viol_cnt` out `CNT_W`: number of RUN→KILL transitions, saturating.

## Operation
Address predicates are unsigned. Constants are computed at `ADDR_W+1` bits so the arithmetic cannot wrap.
- `LAST = REGION_BASE + REGION_SIZE - 2`.
- `pc_in`: `REGION_BASE` ≤ `pc` ≤ `LAST`.
- `addr_in[i]`: `REGION_BASE` ≤ `dma_addr[i]` ≤ `REGION_BASE + REGION_SIZE - 1`.

Cause terms:
- `c_pc_dma = pc_in & |dma_en`.
- `c_addr = GUARD_DMA_ADDR & |(dma_en & addr_in)`.
- `c_irq = CHECK_IRQ & pc_in & irq`.
- `viol` is the OR of the three terms.

The FSM has three states: RUN, KILL and ARMED. Reset puts it in KILL.
- RUN: if `viol`, go to KILL. On that transition:
  - latch `viol_cause = {c_irq, c_addr, c_pc_dma}`;
  - latch `viol_chan` = lowest i with `dma_en[i]` set and contributing to the violation, or 0 if the cause is IRQ only;
  - increment `viol_cnt` (saturating);
  - clear the hold counter.
- KILL: the hold counter increments each cycle. When the count reaches `HOLD_CYCLES` (immediately if `HOLD_CYCLES` is 0) and `viol` is low, go to ARMED. If `viol` is high, clear the hold counter.
- ARMED: if `viol`, go to KILL and clear the hold counter. Otherwise, if `pc == RESET_HANDLER`, go to RUN. Otherwise stay.
- Violations that occur in KILL or ARMED are not counted and do not change `viol_cause` or `viol_chan`.
- `clr_cnt` clears `viol_cnt`. If a clear and an increment fall in the same cycle, the clear wins and `viol_cnt` becomes 0.
- The DMA address check applies in every state. A DMA into the region therefore triggers a kill even while PC is outside it.

## Timing
- All outputs are registered.
- `reset = 1` in KILL and ARMED, and `0` in RUN. `run` is the inverse of `reset`.
- Values while `reset_n = 0`:
  - state KILL;
  - `reset = 1`, `run = 0`;
  - `viol_cause = 0`, `viol_chan = 0`, `viol_cnt = 0`, hold counter 0.
- Detection latency is 1 cycle: `viol` sampled at edge t gives `reset = 1` after edge t.
- Release latency is 1 cycle: `pc == RESET_HANDLER` sampled in ARMED at edge t gives `reset = 0` after edge t.
- Minimum time from RUN→KILL back to RUN is `HOLD_CYCLES + 2` cycles.
- A `reset_n` assertion mid-operation clears everything immediately, including `viol_cnt`.
- The hold counter saturates at `HOLD_CYCLES`.

## Structure
- Package `dma_irq_guard_pkg` holds:
  - the state enum (RUN = 2'd0, KILL = 2'd1, ARMED = 2'd2);
  - the cause bit indices (`CAUSE_PC_DMA = 0`, `CAUSE_ADDR = 1`, `CAUSE_IRQ = 2`).
- Sub-module `region_cmp` is an inclusive [lo, hi] range comparator parametrised by `ADDR_W`. It is instantiated once for `pc` and `N_DMA` times for the DMA addresses.

## Test plan
All scenarios use default parameters.
- Reset release with `pc = 0`:
  - `reset` stays 1 through cycle 4;
  - the block reaches ARMED after 4 KILL cycles;
  - `reset` goes to 0 one cycle later;
  - `viol_cnt = 0`.
- In RUN, `pc = 16'hA010`, `dma_en = 2'b10`:
  - `reset = 1` on the next cycle;
  - `viol_cause = 3'b001`, `viol_chan = 1`, `viol_cnt = 1`.
- In RUN, `pc = 16'h4000`, `dma_en[0] = 1`, `dma_addr[0] = 16'hAFFF`:
  - kill with `viol_cause = 3'b010`, `viol_chan = 0`.
  - Repeat with `dma_addr[0] = 16'hB000`: no kill.
- In RUN, `pc = 16'hAFFE` with `irq`: kill with `viol_cause = 3'b100`. With `pc = 16'hB000` and `irq`: no kill.
- DMA hit held during KILL for 10 cycles, then dropped:
  - ARMED is reached 4 cycles after the drop;
  - `viol_cnt` is unchanged by the violations during KILL.
- `viol_cnt` at 8'hFF plus a new kill: stays at 8'hFF. Then `clr_cnt` in the same cycle as a kill: `viol_cnt = 0`.
